// File: rtl/up_dn_pkg.sv
// Shared definitions for the up/down counter sweep sequencer:
// default widths and the sequencer state encoding.
package up_dn_pkg;

   localparam int WIDTH_DEF = 5;
   localparam int CYC_W_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_UP      = 3'd2,
      ST_DWELL_T = 3'd3,
      ST_DOWN    = 3'd4,
      ST_DWELL_B = 3'd5,
      ST_FINISH  = 3'd6
   } state_t;

endpackage

// File: rtl/up_dn_sweep_ctrl_if.sv
// Host-side handshake and sweep configuration bundle for up_dn_sweep_ctrl.
// The master side is the host; the slave side is the sequencer.
interface up_dn_sweep_ctrl_if
   import up_dn_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CYC_W = CYC_W_DEF
);

   logic             start;
   logic             abort;
   logic [WIDTH-1:0] start_val;
   logic [WIDTH-1:0] top_val;
   logic [WIDTH-1:0] bot_val;
   logic [CYC_W-1:0] cycles;
   logic [CYC_W-1:0] dwell;
   logic             busy;
   logic             done;
   logic             err;
   logic [CYC_W-1:0] cycles_left;

   modport master (
      output start, abort, start_val, top_val, bot_val, cycles, dwell,
      input  busy, done, err, cycles_left
   );

   modport slave (
      input  start, abort, start_val, top_val, bot_val, cycles, dwell,
      output busy, done, err, cycles_left
   );

endinterface

// File: rtl/up_dn_counter.sv
// Plain 5-bit up/down counter with synchronous load and saturating ends.
// It has no reset: its value is meaningful only after the first load.
module up_dn_counter #(
   parameter int WIDTH = 5
)(
   input  logic             clk,
   input  logic             up,
   input  logic             down,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] value,
   output logic             high,
   output logic             low
);

   logic [WIDTH-1:0] value_r;

   // Count register: load has priority, then up, then down.
   always_ff @(posedge clk) begin
      if (load) begin
         value_r <= din;
      end else if (up && (value_r != '1)) begin
         value_r <= value_r + WIDTH'(1);
      end else if (down && (value_r != '0)) begin
         value_r <= value_r - WIDTH'(1);
      end else begin
         value_r <= value_r;
      end
   end

   assign value = value_r;
   assign high  = (value_r == '1);
   assign low   = (value_r == '0);

endmodule

// File: rtl/up_dn_dwell_timer.sv
// Loadable down-counter with a zero flag; shared by both turn-around dwell states.
module up_dn_dwell_timer
   import up_dn_pkg::*;
#(
   parameter int CYC_W = CYC_W_DEF
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             dec,
   input  logic [CYC_W-1:0] load_val,
   output logic             zero
);

   logic [CYC_W-1:0] count_r;

   // Dwell count: load wins over decrement, saturates at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= '0;
      end else if (load) begin
         count_r <= load_val;
      end else if (dec && (count_r != '0)) begin
         count_r <= count_r - CYC_W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign zero = (count_r == '0);

endmodule

// File: rtl/up_dn_sweep_ctrl.sv
// Triangle-sweep sequencer driving one up/down counter: load, ramp to top,
// dwell, ramp to bottom, dwell, repeated N times; Start/Busy/Done/Err with Abort.
module up_dn_sweep_ctrl
   import up_dn_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CYC_W = CYC_W_DEF
)(
   input  logic              clk,
   input  logic              rst_n,
   up_dn_sweep_ctrl_if.slave host,
   input  logic [WIDTH-1:0]  cnt_value,
   input  logic              cnt_high,
   input  logic              cnt_low,
   output logic              cnt_up,
   output logic              cnt_down,
   output logic              cnt_load,
   output logic [WIDTH-1:0]  cnt_in
);

   state_t           state_r;
   state_t           state_nxt_s;
   logic [WIDTH-1:0] start_val_r;
   logic [WIDTH-1:0] top_r;
   logic [WIDTH-1:0] bot_r;
   logic [CYC_W-1:0] dwell_r;
   logic [CYC_W-1:0] cycles_left_r;
   logic             err_r;

   logic cfg_ok_s;
   logic latch_s;
   logic reject_s;
   logic dwell_load_s;
   logic dwell_dec_s;
   logic dwell_zero_s;
   logic left_dec_s;
   logic left_clr_s;
   logic up_s;
   logic down_s;
   logic load_s;

   assign cfg_ok_s = (host.cycles != '0)
                  && (host.bot_val <= host.start_val)
                  && (host.start_val <= host.top_val);

   up_dn_dwell_timer #(
      .CYC_W (CYC_W)
   ) u_dwell (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (dwell_load_s),
      .dec      (dwell_dec_s),
      .load_val (dwell_r),
      .zero     (dwell_zero_s)
   );

   // Next-state and command decode; abort overrides everything in busy states.
   always_comb begin
      state_nxt_s  = state_r;
      up_s         = 1'b0;
      down_s       = 1'b0;
      load_s       = 1'b0;
      latch_s      = 1'b0;
      reject_s     = 1'b0;
      dwell_load_s = 1'b0;
      dwell_dec_s  = 1'b0;
      left_dec_s   = 1'b0;
      left_clr_s   = 1'b0;

      if ((state_r != ST_IDLE) && host.abort) begin
         state_nxt_s = ST_IDLE;
         left_clr_s  = 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (host.start && !host.abort) begin
                  if (cfg_ok_s) begin
                     latch_s     = 1'b1;
                     state_nxt_s = ST_LOAD;
                  end else begin
                     reject_s    = 1'b1;
                  end
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_LOAD: begin
               load_s      = 1'b1;
               state_nxt_s = ST_UP;
            end
            ST_UP: begin
               if (cnt_value == top_r) begin
                  dwell_load_s = 1'b1;
                  state_nxt_s  = ST_DWELL_T;
               end else begin
                  up_s = ~cnt_high;
               end
            end
            ST_DWELL_T: begin
               if (dwell_zero_s) begin
                  state_nxt_s = ST_DOWN;
               end else begin
                  dwell_dec_s = 1'b1;
               end
            end
            ST_DOWN: begin
               if (cnt_value == bot_r) begin
                  if (cycles_left_r == CYC_W'(1)) begin
                     state_nxt_s = ST_FINISH;
                  end else begin
                     left_dec_s   = 1'b1;
                     dwell_load_s = 1'b1;
                     state_nxt_s  = ST_DWELL_B;
                  end
               end else begin
                  down_s = ~cnt_low;
               end
            end
            ST_DWELL_B: begin
               if (dwell_zero_s) begin
                  state_nxt_s = ST_UP;
               end else begin
                  dwell_dec_s = 1'b1;
               end
            end
            ST_FINISH: begin
               left_clr_s  = 1'b1;
               state_nxt_s = ST_IDLE;
            end
            default: begin
               left_clr_s  = 1'b1;
               state_nxt_s = ST_IDLE;
            end
         endcase
      end
   end

   // State register and reject pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         err_r   <= reject_s;
      end
   end

   // Configuration snapshot taken at an accepted start; mid-sweep input changes are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_val_r <= '0;
         top_r       <= '0;
         bot_r       <= '0;
         dwell_r     <= '0;
      end else if (latch_s) begin
         start_val_r <= host.start_val;
         top_r       <= host.top_val;
         bot_r       <= host.bot_val;
         dwell_r     <= host.dwell;
      end else begin
         start_val_r <= start_val_r;
         top_r       <= top_r;
         bot_r       <= bot_r;
         dwell_r     <= dwell_r;
      end
   end

   // Remaining-cycle count, including the cycle in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycles_left_r <= '0;
      end else if (latch_s) begin
         cycles_left_r <= host.cycles;
      end else if (left_clr_s) begin
         cycles_left_r <= '0;
      end else if (left_dec_s) begin
         cycles_left_r <= cycles_left_r - CYC_W'(1);
      end else begin
         cycles_left_r <= cycles_left_r;
      end
   end

   assign cnt_up           = up_s;
   assign cnt_down         = down_s;
   assign cnt_load         = load_s;
   assign cnt_in           = (state_r == ST_LOAD) ? start_val_r : '0;
   assign host.busy        = (state_r != ST_IDLE);
   assign host.done        = (state_r == ST_FINISH) && !host.abort;
   assign host.err         = err_r;
   assign host.cycles_left = cycles_left_r;

endmodule

// File: tb/tb_up_dn_sweep_ctrl.sv
// Bench for up_dn_sweep_ctrl driving a real up/down counter; expected
// per-cycle behaviour is generated from the sweep rules as a queue of steps.
module tb_up_dn_sweep_ctrl;

   localparam int W      = 5;
   localparam int CW     = 4;
   localparam int C_NONE = 0;
   localparam int C_DOWN = 1;
   localparam int C_UP   = 2;
   localparam int C_LOAD = 4;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b1;
   logic         cnt_up;
   logic         cnt_down;
   logic         cnt_load;
   logic         cnt_high;
   logic         cnt_low;
   logic [W-1:0] cnt_in;
   logic [W-1:0] cnt_value;

   int total_cnt = 0;
   int bad_cnt   = 0;
   int final_val = 0;

   typedef struct {
      int cmd;
      int left;
      int done;
      int val;
   } step_t;

   step_t exp_q[$];

   up_dn_sweep_ctrl_if #(.WIDTH(W), .CYC_W(CW)) hif ();

   up_dn_sweep_ctrl #(.WIDTH(W), .CYC_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .host      (hif),
      .cnt_value (cnt_value),
      .cnt_high  (cnt_high),
      .cnt_low   (cnt_low),
      .cnt_up    (cnt_up),
      .cnt_down  (cnt_down),
      .cnt_load  (cnt_load),
      .cnt_in    (cnt_in)
   );

   up_dn_counter #(.WIDTH(W)) u_cnt (
      .clk   (clk),
      .up    (cnt_up),
      .down  (cnt_down),
      .load  (cnt_load),
      .din   (cnt_in),
      .value (cnt_value),
      .high  (cnt_high),
      .low   (cnt_low)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int obs, input int exp);
      total_cnt++;
      if (obs != exp) begin
         bad_cnt++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int obs_cmd();
      return int'({cnt_load, cnt_up, cnt_down});
   endfunction

   function automatic bit cfg_legal(input int sv, input int top, input int bot, input int cyc);
      return (cyc != 0) && (bot <= sv) && (sv <= top);
   endfunction

   task automatic push(input int cmd, input int left, input int done, input int val);
      step_t s;
      s.cmd  = cmd;
      s.left = left;
      s.done = done;
      s.val  = val;
      exp_q.push_back(s);
   endtask

   // Expected per-cycle trace from the first busy cycle to the Done cycle.
   task automatic build(input int sv, input int top, input int bot, input int cyc, input int dw);
      int v;
      int left;
      exp_q.delete();
      left = cyc;
      push(C_LOAD, left, 0, -1);
      v = sv;
      for (int c = 0; c < cyc; c++) begin
         while (v < top) begin
            push(C_UP, left, 0, v);
            v++;
         end
         push(C_NONE, left, 0, v);
         for (int d = 0; d <= dw; d++) push(C_NONE, left, 0, v);
         while (v > bot) begin
            push(C_DOWN, left, 0, v);
            v--;
         end
         push(C_NONE, left, 0, v);
         if (c == cyc - 1) begin
            push(C_NONE, left, 1, v);
         end else begin
            left--;
            for (int d = 0; d <= dw; d++) push(C_NONE, left, 0, v);
         end
      end
      final_val = v;
   endtask

   task automatic drive_cfg(input int sv, input int top, input int bot, input int cyc, input int dw);
      hif.start_val = W'(sv);
      hif.top_val   = W'(top);
      hif.bot_val   = W'(bot);
      hif.cycles    = CW'(cyc);
      hif.dwell     = CW'(dw);
   endtask

   task automatic scramble();
      hif.start_val = W'($urandom);
      hif.top_val   = W'($urandom);
      hif.bot_val   = W'($urandom);
      hif.cycles    = CW'($urandom);
      hif.dwell     = CW'($urandom);
      hif.start     = 1'($urandom);
      hif.abort     = 1'b0;
   endtask

   // cut_kind: 0 none, 1 abort at step cut_idx, 2 reset at step cut_idx.
   task automatic run_sweep(input int sv, input int top, input int bot, input int cyc,
                            input int dw, input int cut_idx, input int cut_kind, input bit scram);
      int cut_val;
      build(sv, top, bot, cyc, dw);
      @(negedge clk);
      drive_cfg(sv, top, bot, cyc, dw);
      hif.start = 1'b1;
      hif.abort = 1'b0;
      #1;
      check_val("start_busy", int'(hif.busy), 0);
      check_val("start_cmd", obs_cmd(), C_NONE);
      @(negedge clk);
      hif.start = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (scram) scramble();
         if (i == cut_idx) begin
            cut_val = exp_q[i].val;
            if (cut_kind == 1) hif.abort = 1'b1;
            else               rst_n     = 1'b0;
            #1;
            check_val("cut_cmd", obs_cmd(), C_NONE);
            check_val("cut_done", int'(hif.done), 0);
            if (cut_kind == 2) begin
               check_val("rst_busy", int'(hif.busy), 0);
               check_val("rst_left", int'(hif.cycles_left), 0);
            end
            @(negedge clk);
            hif.abort = 1'b0;
            hif.start = 1'b0;
            rst_n     = 1'b1;
            #1;
            check_val("cut_idle_busy", int'(hif.busy), 0);
            check_val("cut_idle_left", int'(hif.cycles_left), 0);
            check_val("cut_idle_done", int'(hif.done), 0);
            check_val("cut_idle_cmd", obs_cmd(), C_NONE);
            check_val("cut_hold_val", int'(cnt_value), cut_val);
            return;
         end
         #1;
         check_val("cmd", obs_cmd(), exp_q[i].cmd);
         check_val("busy", int'(hif.busy), 1);
         check_val("done", int'(hif.done), exp_q[i].done);
         check_val("left", int'(hif.cycles_left), exp_q[i].left);
         check_val("err", int'(hif.err), 0);
         check_val("cnt_in", int'(cnt_in), (exp_q[i].cmd == C_LOAD) ? sv : 0);
         check_val("up_at_high", int'(cnt_up & cnt_high), 0);
         check_val("down_at_low", int'(cnt_down & cnt_low), 0);
         if (exp_q[i].val >= 0) check_val("value", int'(cnt_value), exp_q[i].val);
         @(negedge clk);
      end
      hif.start = 1'b0;
      hif.abort = 1'b0;
      #1;
      check_val("end_busy", int'(hif.busy), 0);
      check_val("end_done", int'(hif.done), 0);
      check_val("end_left", int'(hif.cycles_left), 0);
      check_val("end_cmd", obs_cmd(), C_NONE);
      check_val("end_value", int'(cnt_value), final_val);
   endtask

   task automatic run_reject(input int sv, input int top, input int bot, input int cyc,
                             input bit with_abort);
      int v0;
      @(negedge clk);
      v0 = int'(cnt_value);
      drive_cfg(sv, top, bot, cyc, 1);
      hif.start = 1'b1;
      hif.abort = with_abort;
      #1;
      check_val("rej_cmd0", obs_cmd(), C_NONE);
      check_val("rej_err0", int'(hif.err), 0);
      @(negedge clk);
      hif.start = 1'b0;
      hif.abort = 1'b0;
      #1;
      check_val("rej_err", int'(hif.err), (with_abort || cfg_legal(sv, top, bot, cyc)) ? 0 : 1);
      check_val("rej_busy", int'(hif.busy), 0);
      check_val("rej_cmd", obs_cmd(), C_NONE);
      @(negedge clk);
      #1;
      check_val("rej_err_end", int'(hif.err), 0);
      check_val("rej_busy_end", int'(hif.busy), 0);
      check_val("rej_hold", int'(cnt_value), v0);
   endtask

   initial begin
      int idx;
      int sv, top, bot, cyc, dw;
      hif.start = 1'b0;
      hif.abort = 1'b0;
      drive_cfg(0, 0, 0, 0, 0);
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_val("rst_busy", int'(hif.busy), 0);
      check_val("rst_done", int'(hif.done), 0);
      check_val("rst_err", int'(hif.err), 0);
      check_val("rst_left", int'(hif.cycles_left), 0);
      check_val("rst_cmd", obs_cmd(), C_NONE);
      check_val("rst_cnt_in", int'(cnt_in), 0);
      rst_n = 1'b1;

      run_sweep(3, 5, 2, 1, 0, -1, 0, 1'b0);
      run_sweep(0, 31, 0, 3, 2, -1, 0, 1'b0);
      run_reject(7, 31, 0, 0, 1'b0);
      run_reject(7, 5, 2, 1, 1'b0);
      run_reject(3, 5, 2, 1, 1'b1);
      run_sweep(2, 9, 1, 1, 0, 3, 1, 1'b0);

      build(5, 20, 3, 2, 1);
      idx = -1;
      for (int i = 0; i < exp_q.size(); i++) begin
         if ((idx < 0) && (exp_q[i].cmd == C_DOWN)) idx = i;
      end
      run_sweep(5, 20, 3, 2, 1, idx + 2, 2, 1'b0);
      run_sweep(4, 12, 1, 2, 1, -1, 0, 1'b0);
      run_sweep(6, 6, 6, 2, 0, -1, 0, 1'b0);
      run_sweep(8, 8, 2, 1, 1, -1, 0, 1'b1);
      run_sweep(10, 31, 0, 2, 3, -1, 0, 1'b1);

      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(3, 0) == 0) begin
            sv  = int'($urandom_range(31, 0));
            top = int'($urandom_range(31, 0));
            bot = int'($urandom_range(31, 0));
            cyc = int'($urandom_range(15, 0));
            if (cfg_legal(sv, top, bot, cyc)) cyc = 0;
            run_reject(sv, top, bot, cyc, 1'b0);
         end else begin
            bot = int'($urandom_range(31, 0));
            top = int'($urandom_range(31, bot));
            sv  = int'($urandom_range(top, bot));
            cyc = int'($urandom_range(3, 1));
            dw  = int'($urandom_range(3, 0));
            run_sweep(sv, top, bot, cyc, dw, -1, 0, 1'($urandom));
         end
      end

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule

// File: doc/up_dn_sweep_ctrl.md
Name: up_dn_sweep_ctrl

Overview:
- Sequencer that owns the Up/Down/Load/IN command inputs of the 5-bit up/down counter.
- Runs a programmed triangle sweep: load a start value, count up to a top bound, dwell, count down to a bottom bound, dwell, and repeat for N cycles.
- Provides a Start/Busy/Done handshake to the host logic and an Abort path.
- Sits between host control logic and one counter instance; it is the only driver of that counter's inputs.

Parameters:
- WIDTH, 5, counter width; must match the counter instance.
- CYC_W, 4, width of the cycle-count and dwell fields.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_n  in  1  asynchronous active-low reset.
- Start  in  1  begin a sweep; sampled in IDLE only.
- Abort  in  1  terminate the current sweep.
- Start_Val  in  WIDTH  initial counter value.
- Top_Val  in  WIDTH  upper turn-around value.
- Bot_Val  in  WIDTH  lower turn-around value.
- Cycles  in  CYC_W  number of up/down cycles; 0 is illegal.
- Dwell  in  CYC_W  extra hold cycles at each turn-around.
- Cnt_Value  in  WIDTH  counter's registered value.
- Cnt_High  in  1  counter at maximum.
- Cnt_Low  in  1  counter at zero.
- Cnt_Up  out  1  counter Up command.
- Cnt_Down  out  1  counter Down command.
- Cnt_Load  out  1  counter Load command.
- Cnt_IN  out  WIDTH  counter load data.
- Busy  out  1  sweep in progress.
- Done  out  1  one-cycle pulse on normal completion.
- Err  out  1  one-cycle pulse when a Start is rejected.
- Cycles_Left  out  CYC_W  remaining cycles, including the current one.

Behaviour:
- Reset (async assert, synchronous-release usage):
  - State IDLE; all outputs 0; config registers 0.
  - The counter itself has no reset, so Cnt_Value is never compared before the first LOAD.
- Commands:
  - Cnt_Up, Cnt_Down and Cnt_Load are a combinational decode of the state register and Cnt_Value. This gives zero latency and no overshoot.
  - The counter registers each command on the next edge.
  - At most one command is asserted per cycle.
  - Cnt_Up is gated by ~Cnt_High; Cnt_Down is gated by ~Cnt_Low.
  - Cnt_IN equals Start_Val_q during LOAD and 0 otherwise.
- State transitions:
  - IDLE:
    - On Start, check the configuration: Cycles != 0 and Bot_Val <= Start_Val <= Top_Val.
    - Valid: latch all config fields, set Cycles_Left = Cycles, go to LOAD.
    - Invalid: pulse Err for 1 cycle and stay in IDLE.
  - LOAD: assert Cnt_Load; go to UP.
  - UP:
    - If Cnt_Value == Top_q: no command; load the dwell counter with Dwell_q; go to DWELL_T.
    - Otherwise assert Cnt_Up.
  - DWELL_T / DWELL_B:
    - No command issued.
    - If the dwell counter == 0, leave (DWELL_T goes to DOWN, DWELL_B goes to UP); otherwise decrement it.
    - Dwell = 0 therefore costs exactly 1 cycle.
  - DOWN:
    - If Cnt_Value == Bot_q and Cycles_Left == 1: go to FINISH.
    - If Cnt_Value == Bot_q and Cycles_Left > 1: decrement Cycles_Left, load the dwell counter, go to DWELL_B.
    - Otherwise assert Cnt_Down.
  - FINISH: Done = 1 for 1 cycle; Cycles_Left set to 0; go to IDLE.
- Busy is 1 in every state except IDLE.
- Config inputs changing mid-sweep have no effect.
- Start while Busy is ignored.
- Abort:
  - In any busy state, all commands are forced low in that same cycle and the next state is IDLE.
  - Done is not pulsed and Cycles_Left is cleared.
  - The counter holds its current value.
- Start and Abort together in IDLE: Abort wins; no sweep starts and no Err pulse.
- Degenerate configurations:
  - Start_Val == Top_Val: UP exits on its first cycle with no Up command.
  - Top_Val == Bot_Val: legal; each cycle consists of dwells only.
  - Top_Val = 31 and Bot_Val = 0: legal; the High/Low gating never blocks a needed command.
- Reset asserted mid-sweep: immediate return to IDLE with outputs 0; the counter keeps its last value.

Decomposition:
- Shared package up_dn_pkg holds:
  - WIDTH default and the CYC_W default.
  - State encoding localparams: IDLE, LOAD, UP, DWELL_T, DOWN, DWELL_B, FINISH.
- One sub-module, up_dn_dwell_timer: loadable down-counter with a zero flag, instanced once and shared by both dwell states.
- The test bench instantiates up_dn_sweep_ctrl together with a real Up_Dn_Counter.

Test Plan:
- Basic sweep, Start_Val=3 Top=5 Bot=2 Cycles=1 Dwell=0, Start at cycle 0:
  - Cnt_Load in cycle 1; Up in cycles 2-3; DWELL_T in cycle 5; Down in cycles 6-8.
  - Done in cycle 10; Busy low from cycle 11; counter = 2.
- Multi-cycle sweep, Cycles=3 Dwell=2, Start=Bot=0, Top=31:
  - Counter sequence is 0→31→0 three times.
  - Each turn-around holds 3 cycles.
  - Cycles_Left steps 3,2,1 then 0; exactly one Done pulse.
  - Cnt_Up is never asserted while Cnt_High, and Cnt_Down is never asserted while Cnt_Low.
- Rejected configs: Cycles=0, then Start_Val=7 with Top=5:
  - Err pulses 1 cycle each time.
  - Busy stays 0; no counter command is issued.
- Abort during UP with counter at 4: commands go low in the same cycle; IDLE next cycle; no Done; counter holds 4.
- RST_n asserted mid-DOWN:
  - Busy, Done and all commands are 0 immediately.
  - After release, a new Start runs a complete correct sweep.
- Config inputs changed while Busy, plus Start re-asserted: sweep follows the latched values; the second Start is ignored.
